seg_scan_capture: RTL and testbench

Receiving end of the multiplexed 7-segment display bus: samples the scanned digit-enable and segment lines and rebuilds the 32-bit hex value being shown. It is the inverse of the display scanner plus its hex-to-segment encoder. It is used as an on-chip self-check monitor and as a capture front-end for a second board reading our display port. Runs on the fast system clock, asynchronous to the scan clock.

---
 rtl/seg_scan_capture_pkg.sv | 28 ++
 rtl/seg_scan_capture_if.sv | 21 ++
 rtl/seg_scan_capture_seg7_decode.sv | 21 ++
 rtl/seg_scan_capture.sv | 147 ++++++++++++++
 tb/tb_seg_scan_capture.sv | 135 +++++++++++++
 5 files changed

// File: rtl/seg_scan_capture_pkg.sv
// Shared types and tables for the 7-segment scan capture block.
package seg_scan_pkg;

  localparam int NUM_DIGITS = 8;

  typedef enum logic {HUNT, COLLECT} state_e;

  // Active-low a..g patterns (bit 0 = a) for hex glyphs 0..F.
  localparam logic [6:0] GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Returns {one_hot_ok, index} for an active-low digit-enable vector.
  function automatic logic [3:0] en_decode(input logic [7:0] en_n);
    logic [7:0] hot;
    logic [2:0] idx;
    logic       ok;
    hot = ~en_n;
    idx = 3'd0;
    ok  = (hot != 8'd0) && ((hot & (hot - 8'd1)) == 8'd0);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (hot[i]) idx = i[2:0];
    end
    return {ok, idx};
  endfunction

endpackage

// File: rtl/seg_scan_capture_if.sv
// Display-port bus seen by the capture block: scanned lines in, rebuilt value and status out.
interface seg_scan_capture_if;
  logic [7:0]  en_in;
  logic [6:0]  dis_in;
  logic [31:0] data_out;
  logic        frame_valid;
  logic        locked;
  logic        seg_err;
  logic        order_err;
  logic        stale;

  modport master (
    output en_in, dis_in,
    input  data_out, frame_valid, locked, seg_err, order_err, stale
  );

  modport slave (
    input  en_in, dis_in,
    output data_out, frame_valid, locked, seg_err, order_err, stale
  );
endinterface

// File: rtl/seg_scan_capture_seg7_decode.sv
// Inverse glyph lookup: active-low segment pattern to {valid, nibble}.
module seg7_decode
  import seg_scan_pkg::*;
(
  input  logic [6:0] dis_i,
  output logic       valid_o,
  output logic [3:0] nib_o
);

  always_comb begin
    valid_o = 1'b0;
    nib_o   = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (dis_i == GLYPH[i]) begin
        valid_o = 1'b1;
        nib_o   = i[3:0];
      end
    end
  end

endmodule

// File: rtl/seg_scan_capture.sv
// Rebuilds the 32-bit hex value from a scanned, multiplexed 7-segment display bus.
module seg_scan_capture
  import seg_scan_pkg::*;
#(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int CNT_W          = 20
) (
  input logic clk,
  input logic reset,
  seg_scan_capture_if.slave bus
);

  localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAB_MAX  = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_MAX    = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [2:0]       LAST_IDX  = 3'(NUM_DIGITS - 1);

  logic [14:0]                 s1_q, s2_q, prev_q;
  logic [CNT_W-1:0]            stab_q, stab_d, to_q;
  state_e                      state_q;
  logic [2:0]                  exp_q;
  logic [NUM_DIGITS-1:0][3:0]  shadow_q;
  logic                        bad_q;
  logic [31:0]                 data_q;
  logic                        fv_q, seg_err_q, order_err_q, stale_q;

  logic       accept, en_ok, seg_ok;
  logic [2:0] idx;
  logic [3:0] nib;
  logic [3:0] en_dec;

  // Stability counter saturates one past the accept point so a held pair fires once.
  always_comb begin
    stab_d = stab_q;
    if (s2_q != prev_q)        stab_d = '0;
    else if (stab_q != STAB_MAX) stab_d = stab_q + 1'b1;
  end

  assign accept = (stab_q == STAB_LAST);
  assign en_dec = en_decode(prev_q[14:7]);
  assign en_ok  = en_dec[3];
  assign idx    = en_dec[2:0];

  seg7_decode u_dec (
    .dis_i   (prev_q[6:0]),
    .valid_o (seg_ok),
    .nib_o   (nib)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_q   <= '1;
      s2_q   <= '1;
      prev_q <= '1;
      stab_q <= '0;
    end else begin
      s1_q   <= {bus.en_in, bus.dis_in};
      s2_q   <= s1_q;
      prev_q <= s2_q;
      stab_q <= stab_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= HUNT;
      exp_q       <= 3'd0;
      shadow_q    <= '0;
      bad_q       <= 1'b0;
      data_q      <= 32'd0;
      fv_q        <= 1'b0;
      seg_err_q   <= 1'b0;
      order_err_q <= 1'b0;
      stale_q     <= 1'b0;
      to_q        <= '0;
    end else begin
      fv_q        <= 1'b0;
      seg_err_q   <= 1'b0;
      order_err_q <= 1'b0;
      if (accept) begin
        to_q <= '0;
        if (en_ok) begin
          stale_q   <= 1'b0;
          seg_err_q <= !seg_ok;
          case (state_q)
            HUNT: begin
              if (idx == 3'd0) begin
                shadow_q[0] <= nib;
                exp_q       <= 3'd1;
                bad_q       <= !seg_ok;
                state_q     <= COLLECT;
              end
            end
            COLLECT: begin
              if (idx == exp_q) begin
                shadow_q[idx] <= nib;
                if (idx == LAST_IDX) begin
                  if (!bad_q && seg_ok) begin
                    data_q <= {nib, shadow_q[6:0]};
                    fv_q   <= 1'b1;
                  end
                  bad_q   <= 1'b0;
                  state_q <= HUNT;
                end else begin
                  exp_q <= exp_q + 3'd1;
                  bad_q <= bad_q | !seg_ok;
                end
              end else if (idx == exp_q - 3'd1) begin
                shadow_q[idx] <= nib;
                bad_q         <= bad_q | !seg_ok;
              end else begin
                order_err_q <= 1'b1;
                // A jump back to digit 0 is treated as the start of a fresh frame.
                if (idx == 3'd0) begin
                  shadow_q[0] <= nib;
                  exp_q       <= 3'd1;
                  bad_q       <= !seg_ok;
                end else begin
                  bad_q   <= 1'b0;
                  state_q <= HUNT;
                end
              end
            end
            default: state_q <= HUNT;
          endcase
        end
      end else if (to_q == TO_LAST) begin
        to_q    <= TO_MAX;
        stale_q <= 1'b1;
        bad_q   <= 1'b0;
        state_q <= HUNT;
      end else if (to_q != TO_MAX) begin
        to_q <= to_q + 1'b1;
      end
    end
  end

  assign bus.data_out    = data_q;
  assign bus.frame_valid = fv_q;
  assign bus.locked      = (state_q == COLLECT);
  assign bus.seg_err     = seg_err_q;
  assign bus.order_err   = order_err_q;
  assign bus.stale       = stale_q;

endmodule

// File: tb/tb_seg_scan_capture.sv
// Directed bench for seg_scan_capture: scans hex frames onto the display bus and checks the rebuilt value and status.
module tb_seg_scan_capture;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   fv_n = 0;
  int   se_n = 0;
  int   oe_n = 0;

  logic [6:0] G [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  seg_scan_capture_if bus ();

  seg_scan_capture #(
    .STABLE_CYCLES  (4),
    .TIMEOUT_CYCLES (300),
    .CNT_W          (20)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.frame_valid) fv_n++;
    if (bus.seg_err)     se_n++;
    if (bus.order_err)   oe_n++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic show(input int k, input logic [6:0] d, input int dwell);
    @(negedge clk);
    bus.en_in  = ~(8'h01 << k);
    bus.dis_in = d;
    repeat (dwell - 1) @(negedge clk);
  endtask

  task automatic send(input logic [31:0] v, input int lo, input int hi);
    for (int k = lo; k <= hi; k++) show(k, G[v[4*k +: 4]], 20);
  endtask

  initial begin
    bus.en_in  = 8'hFF;
    bus.dis_in = 7'h7F;
    repeat (3) @(negedge clk);
    chk("rst_data", bus.data_out, 32'h0);
    chk("rst_fv", {31'd0, bus.frame_valid}, 32'd0);
    chk("rst_locked", {31'd0, bus.locked}, 32'd0);
    chk("rst_stale", {31'd0, bus.stale}, 32'd0);
    reset = 1'b1;
    repeat (10) @(negedge clk);

    // Clean frame 0x1234ABCD
    send(32'h1234ABCD, 0, 6);
    chk("f1_locked_mid", {31'd0, bus.locked}, 32'd1);
    chk("f1_no_fv_yet", fv_n, 32'd0);
    send(32'h1234ABCD, 7, 7);
    chk("f1_data", bus.data_out, 32'h1234ABCD);
    chk("f1_fv_once", fv_n, 32'd1);
    chk("f1_unlocked", {31'd0, bus.locked}, 32'd0);

    // Scan starting at digit 3, then a full frame
    send(32'hDEADBEEF, 3, 7);
    chk("f2_partial_hold", bus.data_out, 32'h1234ABCD);
    chk("f2_hunt", {31'd0, bus.locked}, 32'd0);
    send(32'hDEADBEEF, 0, 7);
    chk("f2_data", bus.data_out, 32'hDEADBEEF);
    chk("f2_fv", fv_n, 32'd2);
    chk("f2_no_oe", oe_n, 32'd0);

    // Short enable glitch between digits 0 and 1
    send(32'h00000001, 0, 0);
    show(2, G[1], 2);
    send(32'h00000001, 1, 7);
    chk("glitch_data", bus.data_out, 32'h00000001);
    chk("glitch_fv", fv_n, 32'd3);
    chk("glitch_no_oe", oe_n, 32'd0);

    // Blank segments on digit 2 spoil the frame
    send(32'h55AA55AA, 0, 1);
    show(2, 7'h7F, 20);
    send(32'h55AA55AA, 3, 7);
    chk("seg_err_once", se_n, 32'd1);
    chk("seg_no_fv", fv_n, 32'd3);
    chk("seg_data_hold", bus.data_out, 32'h00000001);
    send(32'h55AA55AA, 0, 7);
    chk("seg_next_data", bus.data_out, 32'h55AA55AA);
    chk("seg_next_fv", fv_n, 32'd4);

    // Out-of-order digit sequence 0,1,3
    send(32'h87654321, 0, 1);
    show(3, G[4], 20);
    chk("oe_pulse", oe_n, 32'd1);
    chk("oe_hunt", {31'd0, bus.locked}, 32'd0);
    chk("oe_data_hold", bus.data_out, 32'h55AA55AA);
    chk("oe_no_seg", se_n, 32'd1);

    // Held inputs past the timeout
    repeat (320) @(negedge clk);
    chk("stale_set", {31'd0, bus.stale}, 32'd1);
    chk("stale_data_hold", bus.data_out, 32'h55AA55AA);
    send(32'h87654321, 0, 2);
    chk("stale_clear", {31'd0, bus.stale}, 32'd0);
    chk("relock", {31'd0, bus.locked}, 32'd1);

    // Reset in mid-frame
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_data", bus.data_out, 32'h0);
    chk("mid_rst_locked", {31'd0, bus.locked}, 32'd0);
    chk("mid_rst_stale", {31'd0, bus.stale}, 32'd0);
    chk("mid_rst_flags", {29'd0, bus.frame_valid, bus.seg_err, bus.order_err}, 32'd0);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
